// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow flag (ovf).
//
// Handshake: start is a request that is accepted on a rising clock edge only
// when the subtractor is not busy (busy low, i.e. idle or in its done cycle).
// a/b are captured on that same edge. done is a one-cycle pulse marking the
// first cycle in which diff/bout (and ovf) hold the new result, and they keep
// it until the next done or reset. A start seen while busy is dropped.
interface serial_subtractor_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif
    // FSM state, exported for checkers and debug.
    logic [1:0]   state_dbg;

`ifdef SERIAL_SUB_OVF_EN
    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf, state_dbg
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf, state_dbg
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, bout, state_dbg
    );
    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, state_dbg
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial W-bit subtractor, diff = a - b, LSB first,
// one bit per clock, using one full-subtractor cell and a borrow flop.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow flag computed
// from the captured operand sign bits.
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    // Minuend shift register; result bits are shifted in at the MSB while
    // minuend bits leave at bit 0, so after W shifts it holds the difference.
    logic [W-1:0]  ar;
    logic [W-1:0]  br;
    logic          borrow;
    logic [W-1:0]  diff_q;
    logic          bout_q;
    logic          load;
    logic          last;
    logic          d;
    logic          borrow_n;
`ifdef SERIAL_SUB_OVF_EN
    logic          sign_a;
    logic          sign_b;
    logic          ovf_q;
`endif

    // Full-subtractor cell on the current LSBs.
    assign d        = ar[0] ^ br[0] ^ borrow;
    assign borrow_n = (~ar[0] & br[0]) | (~(ar[0] ^ br[0]) & borrow);

    // Accept a new request when idle or in the done cycle; ignored while busy.
    assign load = bus.start && ((state == IDLE) || (state == DONE));
    assign last = (cnt == CW'(W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = bus.start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, bit-serial datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            ar     <= '0;
            br     <= '0;
            borrow <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else if (load) begin
            cnt    <= '0;
            ar     <= bus.a;
            br     <= bus.b;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sign_a <= bus.a[W-1];
            sign_b <= bus.b[W-1];
`endif
        end else if (state == SHIFT) begin
            cnt    <= cnt + CW'(1);
            ar     <= {d, ar[W-1:1]};
            br     <= {1'b0, br[W-1:1]};
            borrow <= borrow_n;
            // Results change only on the edge entering DONE.
            if (last) begin
                diff_q <= {d, ar[W-1:1]};
                bout_q <= borrow_n;
`ifdef SERIAL_SUB_OVF_EN
                ovf_q  <= (sign_a != sign_b) && (d != sign_a);
`endif
            end
        end
    end

    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.state_dbg = state;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, hand-written multi-cycle sequences and
// randomized operations checked against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    logic [W-1:0] exp_q[$];
    logic         exp_bout_q[$];
    logic         exp_ovf_q[$];

    // Last result the DUT should be holding.
    logic [W-1:0] prev_diff;
    logic         prev_bout;
    logic         prev_ovf;

    vec_t vecs[9];

    serial_subtractor_if #(.W(W)) bus ();

    serial_subtractor #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int ud;
        int sd;
        ud = int'(av) - int'(bv);
        sd = int'($signed(av)) - int'($signed(bv));
        d  = W'(ud);
        bo = (ud < 0);
        ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    endfunction

    task automatic check_outputs_hold(input string tag);
        check({tag, "_diff_hold"}, bus.diff, prev_diff);
        check({tag, "_bout_hold"}, bus.bout, prev_bout);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf_hold"}, bus.ovf, prev_ovf);
`endif
    endtask

    // Driver + scoreboard: one operation. If chained, the caller is at the
    // falling edge of a done cycle and start is raised in that same cycle.
    // poke (1..W) raises start during that busy cycle; 0 disables it.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input bit chained, input int poke);
        logic [W-1:0] got_d;
        logic         got_b;
        logic         got_o;
        exp_q.push_back(ed);
        exp_bout_q.push_back(eb);
        exp_ovf_q.push_back(eo);
        if (!chained) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        for (int c = 1; c <= W; c++) begin
            @(negedge clk);
            bus.start = (c == poke);
            bus.a     = W'($urandom_range(0, (2 ** W) - 1));
            bus.b     = W'($urandom_range(0, (2 ** W) - 1));
            check("busy_in_shift", bus.busy, 1);
            check("done_early", bus.done, 0);
            check_outputs_hold("shift");
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_pulse", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_empty: actual=0 entries required=1");
        end else begin
            got_d = exp_q.pop_front();
            got_b = exp_bout_q.pop_front();
            got_o = exp_ovf_q.pop_front();
            check("diff", bus.diff, got_d);
            check("bout", bus.bout, got_b);
`ifdef SERIAL_SUB_OVF_EN
            check("ovf", bus.ovf, got_o);
`endif
            prev_diff = got_d;
            prev_bout = got_b;
            prev_ovf  = got_o;
        end
    endtask

    task automatic idle_cycle_check();
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("idle_not_busy", bus.busy, 0);
        check_outputs_hold("idle");
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] rd;
        logic         rbo;
        logic         rov;
        int           seen_done;
        bit           chain;

        tests     = 0;
        failed    = 0;
        prev_diff = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;

        vecs[0] = '{a: 8'h5A, b: 8'h23, diff: 8'h37, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h20, diff: 8'hF0, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h05, b: 8'h03, diff: 8'h02, bout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
        vecs[7] = '{a: 8'h00, b: 8'h00, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
        vecs[8] = '{a: 8'h7F, b: 8'h80, diff: 8'hFF, bout: 1'b1, ovf: 1'b1};

        // Reset held for two cycles.
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_diff", bus.diff, 0);
        check("reset_bout", bus.bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", bus.ovf, 0);
`endif

        // Table vectors.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 1'b0, 0);
            idle_cycle_check();
        end

        // Start pulsed in busy cycle 3 is ignored; start on the done cycle
        // launches the next operation immediately.
        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0, 3);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1, 0);
        idle_cycle_check();

        // Reset asserted in cycle 4 of an operation aborts it.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h9C;
        bus.b     = 8'h11;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst       = (c == 4);
        end
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_diff", bus.diff, 0);
        check("abort_bout", bus.bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", bus.ovf, 0);
`endif
        prev_diff = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done++;
        end
        check("abort_no_done", seen_done, 0);

        model(8'hC3, 8'h3C, rd, rbo, rov);
        run_op(8'hC3, 8'h3C, rd, rbo, rov, 1'b0, 0);
        idle_cycle_check();

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h44;
        bus.b     = 8'h01;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_wins_busy", bus.busy, 0);
        check("rst_wins_diff", bus.diff, 0);
        prev_diff = '0;
        prev_bout = 1'b0;
        prev_ovf  = 1'b0;
        @(negedge clk);
        check("rst_wins_still_idle", bus.busy, 0);

        // Randomized operations against the reference model.
        chain = 1'b0;
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom_range(0, (2 ** W) - 1));
            rb = (n % 6 == 5) ? ra : W'($urandom_range(0, (2 ** W) - 1));
            model(ra, rb, rd, rbo, rov);
            run_op(ra, rb, rd, rbo, rov, chain, int'($urandom_range(0, W)));
            chain = 1'($urandom_range(0, 1));
        end
        idle_cycle_check();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
